// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and a doubleword-organised data memory.
// Optional performance counters are enabled with `define LSU_PERF_CNT_EN.
module load_store_unit #(
   parameter int ADDR_W    = 64,
   parameter int MEM_BYTES = 1024
`ifdef LSU_PERF_CNT_EN
   ,parameter int CNT_W    = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [63:0]       mem_rdata
`ifdef LSU_PERF_CNT_EN
   ,output logic [CNT_W-1:0] cnt_loads
   ,output logic [CNT_W-1:0] cnt_stores
   ,output logic [CNT_W-1:0] cnt_errs
`endif
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q;
   logic        write_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [2:0]  off_q;
   logic [63:0] wdata_q;

   logic              misaligned;
   logic              reqErr;
   logic [3:0]        sizeBytes;
   logic [ADDR_W:0]   endAddr;
   logic [5:0]        shamt;
   logic [63:0]       fieldMask;
   logic [63:0]       shifted;
   logic              signBit;
   logic [63:0]       loadData_d;
   logic [63:0]       mergeData_d;

   // The range check is done one bit wider so an address near the top cannot wrap.
   always_comb begin
      sizeBytes = 4'd1 << req_size;
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
      endAddr = {1'b0, req_addr} + (ADDR_W+1)'(sizeBytes);
      reqErr  = misaligned || (endAddr > (ADDR_W+1)'(MEM_BYTES));
   end

   always_comb begin
      shamt = {off_q, 3'b000};
      case (size_q)
         2'b00:   fieldMask = 64'h0000_0000_0000_00FF;
         2'b01:   fieldMask = 64'h0000_0000_0000_FFFF;
         2'b10:   fieldMask = 64'h0000_0000_FFFF_FFFF;
         default: fieldMask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      shifted = mem_rdata >> shamt;
      case (size_q)
         2'b00:   signBit = shifted[7];
         2'b01:   signBit = shifted[15];
         2'b10:   signBit = shifted[31];
         default: signBit = 1'b0;
      endcase
      loadData_d  = (signed_q && signBit) ? (shifted | ~fieldMask) : (shifted & fieldMask);
      mergeData_d = (mem_rdata & ~(fieldMask << shamt)) | ((wdata_q & fieldMask) << shamt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         signed_q  <= 1'b0;
         size_q    <= 2'b00;
         off_q     <= 3'b000;
         wdata_q   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef LSU_PERF_CNT_EN
         cnt_loads  <= '0;
         cnt_stores <= '0;
         cnt_errs   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  signed_q  <= req_signed;
                  size_q    <= req_size;
                  off_q     <= req_addr[2:0];
                  wdata_q   <= req_wdata;
                  if (reqErr) begin
                     state_q   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (!req_write || req_size != 2'b11) begin
                     state_q  <= READ;
                     mem_read <= 1'b1;
                     mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                  end else begin
                     state_q   <= WRITE;
                     mem_write <= 1'b1;
                     mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                     mem_wdata <= req_wdata;
                  end
               end
            end
            READ: begin
               mem_read <= 1'b0;
               if (write_q) begin
                  state_q   <= WRITE;
                  mem_write <= 1'b1;
                  mem_wdata <= mergeData_d;
               end else begin
                  state_q   <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= loadData_d;
               end
            end
            WRITE: begin
               mem_write <= 1'b0;
               state_q   <= RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
            end
            RESP: begin
               state_q   <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
`ifdef LSU_PERF_CNT_EN
               // An errored access counts only as an error, regardless of direction.
               if (rsp_err)
                  cnt_errs <= cnt_errs + CNT_W'(1);
               else if (write_q)
                  cnt_stores <= cnt_stores + CNT_W'(1);
               else
                  cnt_loads <= cnt_loads + CNT_W'(1);
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences for
// reset and back-to-back handshakes, and random accesses against a byte-array memory model.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
   logic [31:0] cnt_loads;
   logic [31:0] cnt_stores;
   logic [31:0] cnt_errs;
`endif

   load_store_unit #(.ADDR_W(64), .MEM_BYTES(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef LSU_PERF_CNT_EN
      , .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_errs(cnt_errs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Doubleword memory the DUT talks to; preloading goes through the same process as DUT writes.
   logic [63:0] mem [128];
   logic        clearEn;
   logic        loadEn;
   logic [6:0]  loadIdx;
   logic [63:0] loadVal;

   assign mem_rdata = mem[mem_addr[9:3]];

   always @(posedge clk) begin
      if (clearEn) begin
         for (int i = 0; i < 128; i++) mem[i] <= '0;
      end else if (loadEn) begin
         mem[loadIdx] <= loadVal;
      end else if (mem_write) begin
         mem[mem_addr[9:3]] <= mem_wdata;
      end
   end

   // Reference model: plain byte array plus per-type completion counts.
   byte unsigned refMem [1024];
   int cntL, cntS, cntE;

   int totalChecks;
   int badChecks;
   int bothHigh;

   logic [63:0] gotData;
   logic        gotErr;
   int          gotLat;
   logic        sawRead;
   logic        sawWrite;
   logic [63:0] lastWrAddr;
   logic [63:0] lastWrData;

   always @(negedge clk) begin
      if (mem_read && mem_write) bothHigh++;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [63:0] val);
      loadIdx = 7'(idx);
      loadVal = val;
      loadEn  = 1'b1;
      @(posedge clk);
      #1 loadEn = 1'b0;
      for (int b = 0; b < 8; b++) refMem[idx*8 + b] = val[8*b +: 8];
   endtask

   function automatic void modelAccess(input bit wr, input bit [1:0] size, input bit sgn,
                                       input logic [63:0] addr, input logic [63:0] wdata,
                                       output logic [63:0] data, output bit err, output int lat);
      int n;
      n    = 1 << size;
      data = '0;
      err  = ((addr % n) != 0) || (addr + n > 1024);
      if (err) begin
         lat = 1;
         cntE++;
      end else if (wr) begin
         for (int i = 0; i < n; i++) refMem[addr + i] = wdata[8*i +: 8];
         lat = (n == 8) ? 2 : 3;
         cntS++;
      end else begin
         for (int i = 0; i < n; i++) data[8*i +: 8] = refMem[addr + i];
         if (sgn && n < 8 && data[8*n - 1]) data = data | ~((64'd1 << (8*n)) - 64'd1);
         lat = 2;
         cntL++;
      end
   endfunction

   // One handshake: drive at a falling edge, then watch up to 10 cycles for the response.
   task automatic applyStimulus(input bit wr, input bit [1:0] size, input bit sgn,
                                input logic [63:0] addr, input logic [63:0] wdata);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      gotLat   = 99;
      gotData  = 64'hDEAD_BEEF_DEAD_BEEF;
      gotErr   = 1'b0;
      sawRead  = 1'b0;
      sawWrite = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_read) sawRead = 1'b1;
         if (mem_write) begin
            sawWrite   = 1'b1;
            lastWrAddr = mem_addr;
            lastWrData = mem_wdata;
         end
         if (rsp_valid) begin
            gotLat  = k;
            gotData = rsp_rdata;
            gotErr  = rsp_err;
            break;
         end
      end
   endtask

   typedef struct {
      bit          wr;
      bit [1:0]    size;
      bit          sgn;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] expData;
      bit          expErr;
      int          expLat;
   } vec_t;

   vec_t vecs [19];

   initial begin
      logic [63:0] mData;
      bit          mErr;
      int          mLat;
      logic [63:0] ra;
      bit          rw;
      bit [1:0]    rs;
      bit          rsg;
      logic [63:0] rwd;
      bit [5:0]    pattern;
      int          diffs;
      logic [63:0] expWord;

      totalChecks = 0;
      badChecks   = 0;
      bothHigh    = 0;
      cntL = 0; cntS = 0; cntE = 0;
      for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      loadEn = 1'b0; loadIdx = '0; loadVal = '0;
      clearEn = 1'b1;

      vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'd8,    64'h0,                  64'h1111_1111_1111_1111, 1'b0, 2};
      vecs[1]  = '{1'b1, 2'd0, 1'b0, 64'd43,   64'hAB,                 64'h0,                   1'b0, 3};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 64'd43,   64'h0,                  64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 2};
      vecs[3]  = '{1'b0, 2'd1, 1'b0, 64'd86,   64'h0,                  64'h0000_0000_0000_AAAA, 1'b0, 2};
      vecs[4]  = '{1'b0, 2'd1, 1'b1, 64'd86,   64'h0,                  64'hFFFF_FFFF_FFFF_AAAA, 1'b0, 2};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 64'd6,    64'h0,                  64'h0,                   1'b1, 1};
      vecs[6]  = '{1'b1, 2'd3, 1'b0, 64'd1024, 64'h1234,               64'h0,                   1'b1, 1};
      vecs[7]  = '{1'b1, 2'd3, 1'b0, 64'd16,   64'h0123_4567_89AB_CDEF, 64'h0,                  1'b0, 2};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 64'd20,   64'h0,                  64'h0000_0000_0123_4567, 1'b0, 2};
      vecs[9]  = '{1'b0, 2'd2, 1'b1, 64'd16,   64'h0,                  64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2};
      vecs[10] = '{1'b1, 2'd0, 1'b0, 64'd17,   64'hFFFF_FFFF_FFFF_FF12, 64'h0,                  1'b0, 3};
      vecs[11] = '{1'b0, 2'd3, 1'b1, 64'd16,   64'h0,                  64'h0123_4567_89AB_12EF, 1'b0, 2};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 64'd1023, 64'h0,                  64'h0,                   1'b1, 1};
      vecs[13] = '{1'b1, 2'd1, 1'b0, 64'd1022, 64'hBEEF,               64'h0,                   1'b0, 3};
      vecs[14] = '{1'b0, 2'd1, 1'b1, 64'd1022, 64'h0,                  64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 2};
      vecs[15] = '{1'b0, 2'd2, 1'b0, 64'd1020, 64'h0,                  64'h0000_0000_BEEF_0000, 1'b0, 2};
      vecs[16] = '{1'b0, 2'd0, 1'b0, 64'd1024, 64'h0,                  64'h0,                   1'b1, 1};
      vecs[17] = '{1'b0, 2'd3, 1'b0, 64'd1020, 64'h0,                  64'h0,                   1'b1, 1};
      vecs[18] = '{1'b0, 2'd0, 1'b0, 64'd43,   64'h0,                  64'h0000_0000_0000_00AB, 1'b0, 2};

      // Reset held for two cycles, then every output must be at its idle value.
      @(posedge clk);
      @(posedge clk);
      #1 clearEn = 1'b0;
      @(negedge clk);
      checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_err",   64'(rsp_err),   64'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata,      64'd0);
      checkOutput("rst_mem_read",  64'(mem_read),  64'd0);
      checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
      checkOutput("rst_mem_addr",  mem_addr,       64'd0);
      checkOutput("rst_mem_wdata", mem_wdata,      64'd0);
`ifdef LSU_PERF_CNT_EN
      checkOutput("rst_counters", 64'({cnt_loads, cnt_stores, cnt_errs} != 0), 64'd0);
`endif

      preload(1,  64'h1111_1111_1111_1111);
      preload(5,  64'h5555_5555_5555_5555);
      preload(10, 64'hAAAA_AAAA_AAAA_AAAA);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed vector table");
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
         modelAccess(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, mData, mErr, mLat);
         checkOutput($sformatf("vec%0d_rdata", i), gotData, vecs[i].expData);
         checkOutput($sformatf("vec%0d_err", i), 64'(gotErr), 64'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_latency", i), 64'(gotLat), 64'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d_memread", i), 64'(sawRead),
                     64'(!vecs[i].expErr && !(vecs[i].wr && vecs[i].size == 2'd3)));
         checkOutput($sformatf("vec%0d_memwrite", i), 64'(sawWrite), 64'(!vecs[i].expErr && vecs[i].wr));
         if (i == 1) begin
            checkOutput("byte_store_mem_addr",  lastWrAddr, 64'd40);
            checkOutput("byte_store_mem_wdata", lastWrData, 64'h5555_5555_AB55_5555);
         end
      end

      // req_valid held high: a new access is taken only once the unit is idle again.
      $display("[TB] held request");
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'd8;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         pattern[5-k] = rsp_valid;
      end
      req_valid = 1'b0;
      cntL += 2;
      checkOutput("held_valid_rsp_pattern", 64'(pattern), 64'(6'b010010));

      $display("[TB] random accesses");
      for (int r = 0; r < 300; r++) begin
         rw  = 1'($urandom_range(0, 1));
         rs  = 2'($urandom_range(0, 3));
         rsg = 1'($urandom_range(0, 1));
         rwd = {$urandom, $urandom};
         ra  = 64'($urandom_range(0, 1031));
         if ($urandom_range(0, 3) != 0) ra = ra - (ra % (64'd1 << rs));
         applyStimulus(rw, rs, rsg, ra, rwd);
         modelAccess(rw, rs, rsg, ra, rwd, mData, mErr, mLat);
         checkOutput($sformatf("rand%0d_rdata", r), gotData, mData);
         checkOutput($sformatf("rand%0d_err", r), 64'(gotErr), 64'(mErr));
         checkOutput($sformatf("rand%0d_latency", r), 64'(gotLat), 64'(mLat));
      end

      // Reset asserted during the READ cycle of a byte store must cancel the write.
      $display("[TB] reset during read-modify-write");
      preload(6, 64'h0F0F_0F0F_0F0F_0F0F);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 64'd50; req_wdata = 64'hCC;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("midrst_in_read", 64'(mem_read), 64'd1);
      rst_n = 1'b0;
      cntL = 0; cntS = 0; cntE = 0;
      sawWrite = 1'b0;
      sawRead  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (mem_write) sawWrite = 1'b1;
         if (rsp_valid) sawRead = 1'b1;
         @(negedge clk);
      end
      checkOutput("midrst_no_write", 64'(sawWrite), 64'd0);
      checkOutput("midrst_no_rsp", 64'(sawRead), 64'd0);
      checkOutput("midrst_ready", 64'(req_ready), 64'd1);
      checkOutput("midrst_mem_kept", mem[6], 64'h0F0F_0F0F_0F0F_0F0F);

      // Two loads, one store and one error after reset.
      applyStimulus(1'b0, 2'd3, 1'b0, 64'd8, 64'h0);
      modelAccess(1'b0, 2'd3, 1'b0, 64'd8, 64'h0, mData, mErr, mLat);
      checkOutput("post_load1", gotData, 64'h1111_1111_1111_1111);
      applyStimulus(1'b1, 2'd2, 1'b0, 64'd52, 64'hDEAD_BEEF);
      modelAccess(1'b1, 2'd2, 1'b0, 64'd52, 64'hDEAD_BEEF, mData, mErr, mLat);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'd48, 64'h0);
      modelAccess(1'b0, 2'd3, 1'b0, 64'd48, 64'h0, mData, mErr, mLat);
      checkOutput("post_load2", gotData, 64'hDEAD_BEEF_0F0F_0F0F);
      applyStimulus(1'b1, 2'd1, 1'b0, 64'd3, 64'h1);
      modelAccess(1'b1, 2'd1, 1'b0, 64'd3, 64'h1, mData, mErr, mLat);
      checkOutput("post_err", 64'(gotErr), 64'd1);
      @(negedge clk);
`ifdef LSU_PERF_CNT_EN
      checkOutput("cnt_loads",  64'(cnt_loads),  64'(cntL));
      checkOutput("cnt_stores", 64'(cnt_stores), 64'(cntS));
      checkOutput("cnt_errs",   64'(cnt_errs),   64'(cntE));
`endif

      diffs = 0;
      for (int i = 0; i < 128; i++) begin
         for (int b = 0; b < 8; b++) expWord[8*b +: 8] = refMem[i*8 + b];
         if (mem[i] !== expWord) diffs++;
      end
      checkOutput("memory_image_diffs", 64'(diffs), 64'd0);
      checkOutput("read_write_overlap", 64'(bothHigh), 64'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
